cpu_wait_gen: RTL

//  Parametrised Z80 WAIT generator. It replaces the fixed "one wait on every M1" flip-flop pair.

---
 rtl/cpu_wait_gen.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_wait_gen.sv
// cpu_wait_gen: parametrised Z80 WAIT generator for the MSX top level.
// Adds a programmable number of wait states per bus-cycle class (M1 fetch,
// memory, I/O). It also merges N_EXT active-low slot wait requests into one
// registered wait_n for the CPU core.
// Optional feature: define VDP_ACCESS_WAIT_EN to enforce a minimum spacing of
// VDP_GAP ce ticks between I/O accesses to the VDP ports 0x98-0x9B.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no bus cycle being stretched; waiting for a strobe rising tick
// COUNT | internal wait counter running, wait_n low
// HOLD  | internal count expired, external slot request still pending
// DONE  | waits finished; wait for the strobe to drop before re-arming

module cpu_wait_gen #(
    parameter int CNT_W     = 4,
    parameter int M1_WAITS  = 1,
    parameter int MEM_WAITS = 0,
    parameter int IO_WAITS  = 0,
    parameter int N_EXT     = 2,
    parameter int VDP_GAP   = 0
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ce_3m58_p,
    input  logic             m1,
    input  logic             mreq,
    input  logic             iorq,
    input  logic [7:0]       addr,
    input  logic [N_EXT-1:0] ext_wait_n,
    output logic             wait_n,
    output logic             busy
);

    localparam int MAX_WAITS = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] M1_LOAD  = CNT_W'(M1_WAITS);
    localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_WAITS);
    localparam logic [CNT_W-1:0] IO_LOAD  = CNT_W'(IO_WAITS);

    // A wait count that does not fit the counter would silently wrap.
    if (M1_WAITS < 0 || M1_WAITS > MAX_WAITS) begin : g_bad_m1
        $error("cpu_wait_gen: M1_WAITS does not fit in CNT_W bits");
    end
    if (MEM_WAITS < 0 || MEM_WAITS > MAX_WAITS) begin : g_bad_mem
        $error("cpu_wait_gen: MEM_WAITS does not fit in CNT_W bits");
    end
    if (IO_WAITS < 0 || IO_WAITS > MAX_WAITS) begin : g_bad_io
        $error("cpu_wait_gen: IO_WAITS does not fit in CNT_W bits");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] base_load;
    logic [CNT_W-1:0] load;
    logic             strb;
    logic             strb_prev;
    logic             ext_any;
    logic             vdp_port;

    assign strb     = mreq | iorq;
    assign ext_any  = ~(&ext_wait_n);
    assign vdp_port = iorq & ~m1 & (addr[7:2] == 6'b100110);

    // Per-class wait count; interrupt acknowledge never waits.
    always_comb begin
        base_load = '0;
        if (iorq && m1) begin
            base_load = '0;
        end else if (m1 && mreq) begin
            base_load = M1_LOAD;
        end else if (mreq) begin
            base_load = MEM_LOAD;
        end else if (iorq) begin
            base_load = IO_LOAD;
        end
    end

`ifdef VDP_ACCESS_WAIT_EN
    localparam logic [7:0] GAP_LOAD = 8'(VDP_GAP);

    logic [7:0]       gap;
    logic [7:0]       gap_dec;
    logic [CNT_W+8:0] gap_sum;
    logic             cyc_vdp;

    // gap_dec is the value the gap counter takes on this tick, so a cycle
    // starting k ticks after the previous VDP access ends sees VDP_GAP-k.
    assign gap_dec = (gap == 8'd0) ? 8'd0 : gap - 8'd1;
    assign gap_sum = (CNT_W+9)'(base_load) + (CNT_W+9)'(gap_dec);

    // VDP I/O cycles inside the spacing window get the remaining gap added.
    always_comb begin
        load = base_load;
        if (vdp_port && gap_dec != 8'd0) begin
            if (gap_sum > (CNT_W+9)'(MAX_WAITS)) begin
                load = CNT_W'(MAX_WAITS);
            end else begin
                load = gap_sum[CNT_W-1:0];
            end
        end
    end

    // Gap counter: reloaded when a VDP cycle leaves DONE, else counts down to 0.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            gap     <= 8'd0;
            cyc_vdp <= 1'b0;
        end else if (ce_3m58_p) begin
            if (state == IDLE && strb && !strb_prev) begin
                cyc_vdp <= vdp_port;
            end
            if (state == DONE && !strb && cyc_vdp) begin
                gap <= GAP_LOAD;
            end else begin
                gap <= gap_dec;
            end
        end
    end
`else
    logic unused_vdp;

    assign load       = base_load;
    assign unused_vdp = ^{vdp_port, 8'(VDP_GAP)};
`endif

    // Next-state logic; everything advances only on CPU clock-enable ticks.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (ce_3m58_p) begin
            if (!strb) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!strb_prev) begin
                            if (load != '0 || ext_any) begin
                                state_nxt = COUNT;
                                cnt_nxt   = load;
                            end else begin
                                state_nxt = DONE;
                            end
                        end
                    end
                    COUNT: begin
                        if (cnt <= CNT_W'(1)) begin
                            cnt_nxt   = '0;
                            state_nxt = ext_any ? HOLD : DONE;
                        end else begin
                            cnt_nxt = cnt - CNT_W'(1);
                        end
                    end
                    HOLD: begin
                        if (!ext_any) begin
                            state_nxt = DONE;
                        end
                    end
                    DONE: begin
                        state_nxt = DONE;
                    end
                    default: begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

    // State, counter and registered wait output. strb_prev resets high so a
    // reset released in the middle of a bus cycle does not restart it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wait_n    <= 1'b1;
            strb_prev <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            wait_n <= ~((state_nxt == COUNT) || (state_nxt == HOLD));
            if (ce_3m58_p) begin
                strb_prev <= strb;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
